// File: rtl/gat_pkg.sv
// Shared constants and state encoding for the GAT new-feature drain path.
package gat_pkg;

   localparam int unsigned NUM_SUBGRAPHS      = 2708;
   localparam int unsigned NUM_FEATURE_OUT    = 16;
   localparam int unsigned NEW_FEATURE_WIDTH  = 32;
   localparam int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
   localparam int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

   // Word index to byte address: 32-bit words on a byte-addressed port.
   localparam int unsigned BYTE_ADDR_SHIFT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_STREAM,
      ST_DONE
   } gat_state_e;

endpackage

// File: rtl/gat_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push and pop may share a cycle.
module gat_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             wdata_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/gat_feat_stream_reader.sv
// Drains the new-feature BRAM in index order onto an AXI4-Stream, using a
// credit-limited read pipeline feeding a small output FIFO.
module gat_feat_stream_reader #(
   parameter int unsigned NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
   parameter int unsigned NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
   parameter int unsigned NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
   parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int unsigned RD_LATENCY         = 2,
   parameter int unsigned FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          gat_ready,
   output logic                          busy,
   output logic                          done,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast
);

   import gat_pkg::*;

   localparam int unsigned IDX_W = NEW_FEATURE_ADDR_W + 1;
   localparam int unsigned AW    = NEW_FEATURE_ADDR_W + 2;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned FW    = NEW_FEATURE_WIDTH + 1;

   gat_state_e             state_q, state_d;
   logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0]  pipe_last_q, pipe_last_d;
   logic [CNT_W-1:0]       inflight_q, inflight_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   issue_c;
   logic                   retire_c;
   logic                   pop_c;
   logic [AW-1:0]          issue_addr_c;
   logic [SUM_W-1:0]       credit_used_c;
   logic [FW-1:0]          fifo_wdata;
   logic [FW-1:0]          fifo_rdata;
   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;

   // A read may issue only while every pipe slot is guaranteed a FIFO entry.
   assign credit_used_c = SUM_W'(fifo_count) + SUM_W'(inflight_q);
   assign issue_c       = (state_q == ST_STREAM)
                          && (rd_idx_q < IDX_W'(NEW_FEATURE_DEPTH))
                          && !fifo_full
                          && (credit_used_c < SUM_W'(FIFO_DEPTH));
   assign issue_addr_c  = AW'(rd_idx_q) << BYTE_ADDR_SHIFT;
   assign retire_c      = pipe_vld_q[RD_LATENCY-1];
   assign pop_c         = !fifo_empty && m_axis_tready;

   // Address is presented in the issue cycle so BRAM latency counts from here.
   assign feat_bram_addrb = issue_c ? issue_addr_c : addr_q;

   assign fifo_wdata    = {pipe_last_q[RD_LATENCY-1], feat_bram_dout};
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[NEW_FEATURE_WIDTH-1:0];
   assign m_axis_tlast  = !fifo_empty && fifo_rdata[FW-1];
   assign busy          = busy_q;
   assign done          = done_q;

   gat_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (retire_c),
      .wdata_i (fifo_wdata),
      .pop_i   (pop_c),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Latency pipe: valid bit plus the tlast tag travel alongside the BRAM read.
   always_comb begin
      pipe_vld_d  = RD_LATENCY'({pipe_vld_q, issue_c});
      pipe_last_d = RD_LATENCY'({pipe_last_q,
                                 issue_c && (rd_idx_q == IDX_W'(NEW_FEATURE_DEPTH - 1))});
      inflight_d  = inflight_q + CNT_W'(issue_c) - CNT_W'(retire_c);
   end

   always_comb begin
      state_d    = state_q;
      rd_idx_d   = rd_idx_q;
      beat_idx_d = beat_idx_q;
      addr_d     = addr_q;
      case (state_q)
         ST_IDLE: begin
            rd_idx_d   = '0;
            beat_idx_d = '0;
            if (start) begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (gat_ready) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (issue_c) begin
               rd_idx_d = rd_idx_q + IDX_W'(1);
               addr_d   = issue_addr_c;
            end
            if (pop_c) begin
               beat_idx_d = beat_idx_q + IDX_W'(1);
            end
            if (pop_c && (beat_idx_q == IDX_W'(NEW_FEATURE_DEPTH - 1))
                && (rd_idx_q == IDX_W'(NEW_FEATURE_DEPTH))) begin
               state_d = ST_DONE;
               addr_d  = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_idx_q    <= '0;
         beat_idx_q  <= '0;
         addr_q      <= '0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         inflight_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         beat_idx_q  <= beat_idx_d;
         addr_q      <= addr_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         inflight_q  <= inflight_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_gat_feat_stream_reader.sv
// Scoreboard bench for gat_feat_stream_reader: 8-word BRAM (word[i]=A0000000+i),
// reference instance at RD_LATENCY=2 plus latency-1 and latency-4 instances.
module tb_gat_feat_stream_reader;

   localparam int unsigned NI = 3;
   localparam int unsigned NW = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       gat_ready;
   logic       tready;

   logic        busy_w   [NI];
   logic        done_w   [NI];
   logic        tvalid_w [NI];
   logic        tlast_w  [NI];
   logic [4:0]  addrb_w  [NI];
   logic [31:0] dout_w   [NI];
   logic [31:0] tdata_w  [NI];

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [32:0] exp_q [$];
   int          pops_run;
   int          dones;
   int          out_max;
   logic [4:0]  max_addr;
   logic [4:0]  last_addr;
   int          beat_idx  [NI];
   int          first_cyc [NI];
   int          last_cyc  [NI];
   bit          stalled;
   logic [32:0] held;
   logic [3:0]  bp_pat = 4'b1001;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < int'(NI); g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      localparam int unsigned FD  = (g == 0) ? 4 : 8;
      logic [31:0] bram_q [LAT];

      gat_feat_stream_reader #(
         .NEW_FEATURE_WIDTH (32),
         .NUM_SUBGRAPHS     (2),
         .NUM_FEATURE_OUT   (4),
         .RD_LATENCY        (LAT),
         .FIFO_DEPTH        (FD)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .start           (start),
         .gat_ready       (gat_ready),
         .busy            (busy_w[g]),
         .done            (done_w[g]),
         .feat_bram_addrb (addrb_w[g]),
         .feat_bram_dout  (dout_w[g]),
         .m_axis_tdata    (tdata_w[g]),
         .m_axis_tvalid   (tvalid_w[g]),
         .m_axis_tready   (tready),
         .m_axis_tlast    (tlast_w[g])
      );

      // BRAM model: LAT register stages from address to data.
      always @(posedge clk) begin
         bram_q[0] <= 32'hA000_0000 + 32'(addrb_w[g] >> 2);
         for (int k = 1; k < int'(LAT); k++) bram_q[k] <= bram_q[k-1];
      end
      assign dout_w[g] = bram_q[LAT-1];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [32:0] e;
      int          outst;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            for (int g = 0; g < int'(NI); g++) beat_idx[g] = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", 64'(tvalid_w[0]), 64'd1);
               check("hold_beat", 64'({tlast_w[0], tdata_w[0]}), 64'(held));
            end
            if (busy_w[0]) begin
               if (addrb_w[0] > max_addr) max_addr = addrb_w[0];
               if ((addrb_w[0] != last_addr) && (addrb_w[0] != 5'd0)) begin
                  check("addr_step", 64'(addrb_w[0]), 64'(last_addr + 5'd4));
                  last_addr = addrb_w[0];
               end
               outst = int'(max_addr >> 2) + 1 - pops_run;
               if (outst > out_max) out_max = outst;
               check("credit_bound", 64'(outst <= 4), 64'd1);
            end
            if (tvalid_w[0] && tready) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat", 64'(exp_q.size()), 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 64'({tlast_w[0], tdata_w[0]}), 64'(e));
               end
               pops_run++;
            end
            stalled = tvalid_w[0] && !tready;
            held    = {tlast_w[0], tdata_w[0]};
            if (done_w[0]) dones++;
            for (int g = 0; g < int'(NI); g++) begin
               if (tvalid_w[g] && tready) begin
                  if (g > 0) begin
                     check($sformatf("sweep_beat_%0d", g), 64'({tlast_w[g], tdata_w[g]}),
                           64'({beat_idx[g] == 7, 32'hA000_0000 + 32'(beat_idx[g])}));
                  end
                  if (beat_idx[g] == 0) first_cyc[g] = cyc;
                  if (tlast_w[g]) last_cyc[g] = cyc;
                  beat_idx[g] = (beat_idx[g] + 1) % int'(NW);
               end
            end
         end
      end
   endtask

   task automatic reset_tracking();
      pops_run  = 0;
      dones     = 0;
      out_max   = 0;
      max_addr  = '0;
      last_addr = '0;
   endtask

   task automatic push_run();
      for (int i = 0; i < int'(NW); i++) exp_q.push_back({i == 7, 32'hA000_0000 + 32'(i)});
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pad(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit bp);
      bit got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (bp) tready = bp_pat[k % 4];
         if (done_w[0]) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(got), 64'd1);
      if (got) begin
         check("busy_in_done", 64'(busy_w[0]), 64'd1);
         @(posedge clk); #1;
         check("busy_after_done", 64'(busy_w[0]), 64'd0);
         check("done_one_cycle", 64'(done_w[0]), 64'd0);
      end
      tready = 1'b1;
   endtask

   initial begin
      bit got;
      rst_n     = 1'b0;
      start     = 1'b0;
      gat_ready = 1'b0;
      tready    = 1'b0;
      stalled   = 1'b0;
      for (int g = 0; g < int'(NI); g++) begin
         beat_idx[g]  = 0;
         first_cyc[g] = 0;
         last_cyc[g]  = 0;
      end
      reset_tracking();
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy_w[0]), 64'd0);
      check("rst_done", 64'(done_w[0]), 64'd0);
      check("rst_addrb", 64'(addrb_w[0]), 64'd0);
      check("rst_tvalid", 64'(tvalid_w[0]), 64'd0);
      check("rst_tlast", 64'(tlast_w[0]), 64'd0);
      check("rst_tdata", 64'(tdata_w[0]), 64'd0);
      rst_n = 1'b1;
      pad(2);

      // Full rate, all latencies
      gat_ready = 1'b1;
      tready    = 1'b1;
      reset_tracking();
      push_run();
      pulse_start();
      wait_done(1'b0);
      pad(10);
      check("full_dones", 64'(dones), 64'd1);
      check("full_drained", 64'(exp_q.size()), 64'd0);
      check("full_last_addr", 64'(max_addr), 64'h1C);
      for (int g = 0; g < int'(NI); g++) begin
         check($sformatf("full_span_%0d", g), 64'(last_cyc[g] - first_cyc[g]), 64'd7);
      end

      // Backpressure 1,0,0,1
      reset_tracking();
      tready = bp_pat[0];
      push_run();
      pulse_start();
      wait_done(1'b1);
      pad(10);
      check("bp_dones", 64'(dones), 64'd1);
      check("bp_drained", 64'(exp_q.size()), 64'd0);
      check("bp_credit_peak", 64'(out_max), 64'd4);

      // Late gat_ready
      gat_ready = 1'b0;
      reset_tracking();
      push_run();
      pulse_start();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("late_addrb", 64'(addrb_w[0]), 64'd0);
         check("late_tvalid", 64'(tvalid_w[0]), 64'd0);
      end
      @(posedge clk); #1 gat_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("late_first_quiet", 64'(tvalid_w[0]), 64'd0);
      end
      @(negedge clk);
      check("late_first_beat", 64'(tvalid_w[0]), 64'd1);
      wait_done(1'b0);
      pad(10);
      check("late_drained", 64'(exp_q.size()), 64'd0);

      // Start during STREAM is ignored
      reset_tracking();
      push_run();
      pulse_start();
      pad(3);
      pulse_start();
      wait_done(1'b0);
      pad(20);
      check("ign_dones", 64'(dones), 64'd1);
      check("ign_drained", 64'(exp_q.size()), 64'd0);

      // Async reset mid-stream, then restream
      reset_tracking();
      push_run();
      pulse_start();
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (pops_run >= 4) begin
            got = 1'b1;
            break;
         end
      end
      check("mid_reach_beat3", 64'(got), 64'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(tvalid_w[0]), 64'd0);
      check("mid_rst_busy", 64'(busy_w[0]), 64'd0);
      check("mid_rst_addrb", 64'(addrb_w[0]), 64'd0);
      check("mid_rst_done", 64'(done_w[0]), 64'd0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      reset_tracking();
      push_run();
      pulse_start();
      wait_done(1'b0);
      pad(10);
      check("restream_dones", 64'(dones), 64'd1);
      check("restream_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
